// File: rtl/seg_decoder.sv
// Seven-segment display bus decoder: waits for a stable bus pattern, then decodes one digit.
// Optional SEG_DECODER_HEX_EN extends the segment table with hex digits A..F.
module seg_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_in,
   input  logic [11:0] seg_in,
   output logic        valid,
   output logic        err,
   output logic [1:0]  digit_idx,
   output logic [3:0]  digit_val,
   output logic        dp_out,
   output logic [15:0] hex_word
);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   localparam logic [7:0] THRESH = 8'(STABLE_CYCLES);

   state_t      state;
   logic [11:0] seg_q;
   logic [11:0] seg_p;
   logic [7:0]  cnt;

   logic        an_ok;
   logic        seg_ok;
   logic [1:0]  dec_idx;
   logic [3:0]  dec_val;

   always_comb begin
      an_ok   = 1'b0;
      dec_idx = '0;
      case (seg_q[11:8])
         4'b1110: begin an_ok = 1'b1; dec_idx = 2'd0; end
         4'b1101: begin an_ok = 1'b1; dec_idx = 2'd1; end
         4'b1011: begin an_ok = 1'b1; dec_idx = 2'd2; end
         4'b0111: begin an_ok = 1'b1; dec_idx = 2'd3; end
         default: ;
      endcase

      seg_ok  = 1'b1;
      dec_val = '0;
      case (seg_q[7:1])
         7'b0000001: dec_val = 4'h0;
         7'b1001111: dec_val = 4'h1;
         7'b0010010: dec_val = 4'h2;
         7'b0000110: dec_val = 4'h3;
         7'b1001100: dec_val = 4'h4;
         7'b0100100: dec_val = 4'h5;
         7'b0100000: dec_val = 4'h6;
         7'b0001111: dec_val = 4'h7;
         7'b0000000: dec_val = 4'h8;
         7'b0000100: dec_val = 4'h9;
`ifdef SEG_DECODER_HEX_EN
         7'b0001000: dec_val = 4'hA;
         7'b1100000: dec_val = 4'hB;
         7'b0110001: dec_val = 4'hC;
         7'b1000010: dec_val = 4'hD;
         7'b0110000: dec_val = 4'hE;
         7'b0111000: dec_val = 4'hF;
`endif
         default:    seg_ok = 1'b0;
      endcase
   end

   // seg_p holds the previous seg_q so that a change is seen one cycle after sampling
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         state     <= IDLE;
         cnt       <= '0;
         seg_q     <= 12'hFFF;
         seg_p     <= 12'hFFF;
         valid     <= 1'b0;
         err       <= 1'b0;
         digit_idx <= '0;
         digit_val <= '0;
         dp_out    <= 1'b0;
         hex_word  <= '0;
      end else begin
         seg_q <= seg_in;
         seg_p <= seg_q;
         valid <= 1'b0;
         err   <= 1'b0;
         if (seg_q[11:8] == 4'hF) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (seg_q != seg_p) begin
            state <= SETTLE;
            cnt   <= '0;
         end else begin
            case (state)
               SETTLE: begin
                  cnt <= cnt + 8'd1;
                  if (cnt == THRESH - 8'd1) begin
                     state <= HOLD;
                     if (an_ok && seg_ok) begin
                        valid                          <= 1'b1;
                        digit_idx                      <= dec_idx;
                        digit_val                      <= dec_val;
                        dp_out                         <= ~seg_q[0];
                        hex_word[{dec_idx, 2'b00} +: 4] <= dec_val;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               HOLD: begin
                  if (cnt != '1) cnt <= cnt + 8'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
